// File: rtl/mii_phy_tx_gen.sv
// MII nibble generator: AXI-Stream bytes in, preamble/SFD/data nibbles out
// toward a MAC receiver, with bad-frame marking, underflow drop and IFG.
module mii_phy_tx_gen #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter bit DEFAULT_ER_ON_UNDERFLOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] mii_d,
  output logic       mii_dv,
  output logic       mii_er,
  input  logic [7:0] cfg_ifg,
  input  logic       cfg_enable,
  output logic       stat_start_packet,
  output logic       stat_error_underflow
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA_LO,
    DATA_HI,
    DROP,
    IFG
  } state_t;

  localparam logic [8:0] PRE_N = 9'(PREAMBLE_NIBBLES);

  state_t     state, state_nx;
  logic [8:0] cnt, cnt_nx;
  logic [7:0] byte_q, byte_nx;
  logic       last_q, last_nx;
  logic       bad_q, bad_nx;
  logic [3:0] d_nx;
  logic       dv_nx, er_nx;
  logic       sop_nx, unf_nx;
  logic [8:0] ifg_len;

  // Gap is counted in nibbles: two per byte time, never below one byte.
  assign ifg_len = (cfg_ifg == 8'd0) ? 9'd2 : {cfg_ifg, 1'b0};

  always_comb begin
    s_axis_tready = 1'b0;
    unique case (state)
      SFD:     s_axis_tready = 1'b1;
      DATA_HI: s_axis_tready = !last_q;
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    byte_nx  = byte_q;
    last_nx  = last_q;
    bad_nx   = bad_q;
    d_nx     = 4'h0;
    dv_nx    = 1'b0;
    er_nx    = 1'b0;
    sop_nx   = 1'b0;
    unf_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_axis_tvalid && cfg_enable) begin
          state_nx = PREAMBLE;
          cnt_nx   = 9'd1;
          d_nx     = 4'h5;
          dv_nx    = 1'b1;
          sop_nx   = 1'b1;
        end
      end
      PREAMBLE: begin
        dv_nx = 1'b1;
        if (cnt == PRE_N) begin
          state_nx = SFD;
          d_nx     = 4'hD;
        end else begin
          cnt_nx = cnt + 9'd1;
          d_nx   = 4'h5;
        end
      end
      SFD, DATA_HI: begin
        if (state == DATA_HI && last_q) begin
          state_nx = IFG;
          cnt_nx   = ifg_len;
        end else if (s_axis_tvalid) begin
          state_nx = DATA_LO;
          byte_nx  = s_axis_tdata;
          last_nx  = s_axis_tlast;
          bad_nx   = s_axis_tlast && s_axis_tuser;
          d_nx     = s_axis_tdata[3:0];
          dv_nx    = 1'b1;
          er_nx    = s_axis_tlast && s_axis_tuser;
        end else begin
          state_nx = DROP;
          dv_nx    = 1'b1;
          er_nx    = DEFAULT_ER_ON_UNDERFLOW;
          unf_nx   = 1'b1;
        end
      end
      DATA_LO: begin
        state_nx = DATA_HI;
        d_nx     = byte_q[7:4];
        dv_nx    = 1'b1;
        er_nx    = bad_q;
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nx = IFG;
          cnt_nx   = ifg_len;
        end
      end
      IFG: begin
        if (cnt > 9'd1) begin
          cnt_nx = cnt - 9'd1;
        end else if (s_axis_tvalid && cfg_enable) begin
          state_nx = PREAMBLE;
          cnt_nx   = 9'd1;
          d_nx     = 4'h5;
          dv_nx    = 1'b1;
          sop_nx   = 1'b1;
        end else begin
          state_nx = IDLE;
          cnt_nx   = 9'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= 9'd0;
      byte_q               <= 8'd0;
      last_q               <= 1'b0;
      bad_q                <= 1'b0;
      mii_d                <= 4'h0;
      mii_dv               <= 1'b0;
      mii_er               <= 1'b0;
      stat_start_packet    <= 1'b0;
      stat_error_underflow <= 1'b0;
    end else begin
      state                <= state_nx;
      cnt                  <= cnt_nx;
      byte_q               <= byte_nx;
      last_q               <= last_nx;
      bad_q                <= bad_nx;
      mii_d                <= d_nx;
      mii_dv               <= dv_nx;
      mii_er               <= er_nx;
      stat_start_packet    <= sop_nx;
      stat_error_underflow <= unf_nx;
    end
  end

endmodule

// File: tb/tb_mii_phy_tx_gen.sv
// Bench for mii_phy_tx_gen: directed reset/enable cases plus randomized
// frames scored against a frame-level nibble model.
module tb_mii_phy_tx_gen;

  localparam int PN = 15;
  localparam bit ERP = 1'b1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [3:0] mii_d;
  logic       mii_dv;
  logic       mii_er;
  logic [7:0] cfg_ifg;
  logic       cfg_enable;
  logic       stat_start_packet;
  logic       stat_error_underflow;

  always #5 clk = ~clk;

  mii_phy_tx_gen #(
    .PREAMBLE_NIBBLES(PN),
    .DEFAULT_ER_ON_UNDERFLOW(ERP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .mii_d(mii_d),
    .mii_dv(mii_dv),
    .mii_er(mii_er),
    .cfg_ifg(cfg_ifg),
    .cfg_enable(cfg_enable),
    .stat_start_packet(stat_start_packet),
    .stat_error_underflow(stat_error_underflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         hold;
  } beat_t;

  typedef struct {
    logic [3:0] d;
    logic       er;
    logic       unf;
  } nib_t;

  beat_t      beats[$];
  nib_t       nib_q[$];
  int         len_q[$];
  int         gap_q[$];
  logic [7:0] pl[$];

  int ifg_v = 12;
  bit prev_ok = 0;
  bit drv_en = 0;
  bit mon_en = 0;
  bit rnd_en = 0;
  bit fire = 0;
  int hold_cnt = 0;
  bit in_frame = 0;
  int pos = 0;
  int cur_len = 0;
  int dv0_run = 0;
  int tr_cyc = 0;
  int g;

  function automatic void add_nib(input logic [3:0] d, input logic er,
                                  input logic unf);
    nib_t nb;
    nb.d = d;
    nb.er = er;
    nb.unf = unf;
    nib_q.push_back(nb);
  endfunction

  // Expected wire view of one frame; unf_k>0 makes beat unf_k arrive late.
  function automatic void gen_frame(input int len, input bit bad,
                                    input int unf_k, input bit jit);
    int n;
    int gap;
    gap = (ifg_v < 1) ? 2 : 2 * ifg_v;
    gap_q.push_back(prev_ok ? gap : -1);
    for (int i = 0; i < PN; i++) add_nib(4'h5, 1'b0, 1'b0);
    add_nib(4'hD, 1'b0, 1'b0);
    n = PN + 1;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = (pl.size() > 0) ? pl.pop_front() : 8'($urandom);
      b.last = (i == len - 1);
      b.user = b.last && bad;
      if (unf_k != 0 && i == unf_k) b.hold = $urandom_range(2, 5);
      else if (!jit) b.hold = 0;
      else if (i == 0) b.hold = $urandom_range(0, 3);
      else b.hold = $urandom_range(0, 1);
      beats.push_back(b);
      if (unf_k == 0 || i < unf_k) begin
        add_nib(b.data[3:0], b.user, 1'b0);
        add_nib(b.data[7:4], b.user, 1'b0);
        n += 2;
      end
    end
    if (unf_k != 0) begin
      add_nib(4'h0, ERP, 1'b1);
      n++;
    end
    len_q.push_back(n);
    prev_ok = (unf_k == 0);
  endfunction

  task automatic monitor();
    nib_t e;
    if (mii_dv) begin
      if (!in_frame) begin
        in_frame = 1;
        pos = 0;
        chk("sop", 32'(stat_start_packet), 1);
        chk("frame_pending", 32'(len_q.size() > 0), 1);
        cur_len = (len_q.size() > 0) ? len_q.pop_front() : 0;
        if (gap_q.size() > 0) begin
          g = gap_q.pop_front();
          if (g >= 0) chk("ifg_gap", dv0_run, g);
        end
      end else begin
        chk("sop_once", 32'(stat_start_packet), 0);
      end
      chk("nib_pending", 32'(nib_q.size() > 0), 1);
      if (nib_q.size() > 0) begin
        e = nib_q.pop_front();
        chk("nib_d", 32'(mii_d), 32'(e.d));
        chk("nib_er", 32'(mii_er), 32'(e.er));
        chk("unf_pulse", 32'(stat_error_underflow), 32'(e.unf));
      end
      pos++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        chk("frame_len", pos, cur_len);
        dv0_run = 0;
      end
      dv0_run++;
      chk("gap_er", 32'(mii_er), 0);
      chk("gap_sop", 32'(stat_start_packet), 0);
      chk("gap_unf", 32'(stat_error_underflow), 0);
    end
  endtask

  task automatic step();
    beat_t tmp;
    @(negedge clk);
    if (mon_en) monitor();
    if (mon_en && s_axis_tready) tr_cyc++;
    if (drv_en) begin
      if (fire) begin
        tmp = beats.pop_front();
        hold_cnt = (beats.size() > 0) ? beats[0].hold : 0;
      end
      if (beats.size() == 0) begin
        s_axis_tvalid = 1'b0;
      end else if (hold_cnt > 0) begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata = 8'($urandom);
        s_axis_tlast = 1'($urandom);
        s_axis_tuser = 1'($urandom);
        hold_cnt--;
      end else begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata = beats[0].data;
        s_axis_tlast = beats[0].last;
        s_axis_tuser = beats[0].user;
      end
      if (rnd_en) cfg_enable = mii_dv ? 1'($urandom) : 1'b1;
      fire = s_axis_tvalid && s_axis_tready;
    end
  endtask

  task automatic run_phase(input int budget);
    int cyc = 0;
    hold_cnt = (beats.size() > 0) ? beats[0].hold : 0;
    fire = 0;
    dv0_run = 0;
    in_frame = 0;
    drv_en = 1;
    mon_en = 1;
    while ((beats.size() > 0 || nib_q.size() > 0 || in_frame)
           && cyc < budget) begin
      step();
      cyc++;
    end
    chk("phase_in_budget", 32'(cyc < budget), 1);
    repeat (40) step();
    chk("frames_left", len_q.size(), 0);
    drv_en = 0;
    mon_en = 0;
    rnd_en = 0;
    cfg_enable = 1'b1;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    cfg_ifg = 8'd12;
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_d", 32'(mii_d), 0);
    chk("rst_dv", 32'(mii_dv), 0);
    chk("rst_er", 32'(mii_er), 0);
    chk("rst_tready", 32'(s_axis_tready), 0);
    chk("rst_sop", 32'(stat_start_packet), 0);
    chk("rst_unf", 32'(stat_error_underflow), 0);

    // Enable gating: a waiting byte must not start a frame.
    rst = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h3C;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mii_dv || s_axis_tready) bad++;
    end
    chk("enable_block", bad, 0);
    cfg_enable = 1'b1;
    @(negedge clk);
    chk("enable_start_dv", 32'(mii_dv), 1);
    chk("enable_start_d", 32'(mii_d), 5);
    chk("enable_start_sop", 32'(stat_start_packet), 1);

    // Reset in DATA_LO aborts without IFG; next frame gets a full preamble.
    n = 0;
    while (!(mii_dv && mii_d == 4'hC) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_lo", 32'(n < 40), 1);
    rst = 1'b1;
    s_axis_tdata = 8'h7E;
    s_axis_tlast = 1'b1;
    @(negedge clk);
    chk("midrst_dv", 32'(mii_dv), 0);
    chk("midrst_er", 32'(mii_er), 0);
    chk("midrst_d", 32'(mii_d), 0);
    chk("midrst_tready", 32'(s_axis_tready), 0);
    rst = 1'b0;
    @(negedge clk);
    n = 0;
    while (mii_dv && mii_d == 4'h5 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("restart_preamble", n, PN);
    chk("restart_sfd", 32'(mii_d), 32'hD);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("restart_lo", 32'(mii_d), 32'hE);
    @(negedge clk);
    chk("restart_hi", 32'(mii_d), 32'h7);
    chk("restart_hi_dv", 32'(mii_dv), 1);
    @(negedge clk);
    chk("restart_end_dv", 32'(mii_dv), 0);
    repeat (30) @(negedge clk);

    // Two-byte frame then one-byte bad frame, 12-byte IFG.
    ifg_v = 12;
    cfg_ifg = 8'(ifg_v);
    prev_ok = 0;
    tr_cyc = 0;
    pl.push_back(8'h11);
    pl.push_back(8'h22);
    gen_frame(2, 1'b0, 0, 1'b0);
    pl.push_back(8'hA5);
    gen_frame(1, 1'b1, 0, 1'b0);
    run_phase(500);
    chk("tready_cycles", tr_cyc, 3);

    // Back-to-back 64-byte frames with minimum gap.
    ifg_v = 0;
    cfg_ifg = 8'd0;
    prev_ok = 0;
    gen_frame(64, 1'b0, 0, 1'b0);
    gen_frame(64, 1'b0, 0, 1'b0);
    run_phase(1000);

    // Underflow after the first byte of a three-byte frame.
    ifg_v = 5;
    cfg_ifg = 8'd5;
    prev_ok = 0;
    gen_frame(3, 1'b0, 1, 1'b0);
    gen_frame(4, 1'b0, 0, 1'b0);
    run_phase(500);

    // Randomized frames, stalls, underflows and mid-frame enable toggling.
    for (int p = 0; p < 3; p++) begin
      ifg_v = $urandom_range(1, 4);
      cfg_ifg = 8'(ifg_v);
      prev_ok = 0;
      rnd_en = 1;
      for (int f = 0; f < 10; f++) begin
        int len;
        int uk;
        len = $urandom_range(1, 20);
        uk = (len >= 2 && $urandom_range(0, 3) == 0)
             ? $urandom_range(1, len - 1) : 0;
        gen_frame(len, 1'($urandom), uk, 1'b1);
      end
      run_phase(5000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
